fetch_stage: RTL and testbench

//  IF stage driving the IF/ID pipeline register: owns the PC, issues instruction-memory reads,

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_pc_reg.sv | 19 +
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: widths, default parameters, FSM encoding.
package fetch_stage_pkg;

  localparam int unsigned XLEN  = 16;
  localparam int unsigned OPC_W = 5;

  localparam logic [XLEN-1:0]  RESET_PC_DEF  = 16'h0000;
  localparam logic [XLEN-1:0]  NOP_INSTR_DEF = 16'h0800;
  localparam logic [OPC_W-1:0] HALT_OPC_DEF  = 5'b00000;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  function automatic logic [OPC_W-1:0] opcode(input logic [XLEN-1:0] instr);
    return instr[XLEN-1:XLEN-OPC_W];
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Address register with load enable; used for both the PC and the deferred redirect target.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VAL = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem reads and presents instruction/pc+2/bubble flag to IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0]  RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0]  NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [OPC_W-1:0] HALT_OPC  = HALT_OPC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_fetch,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [XLEN-1:0] imem_data,
  input  logic            imem_done,
  input  logic            imem_stall,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] incremented_pc,
  output logic            flush_fetch,
  output logic            halted
);

  logic [1:0]      state, state_nxt;
  logic            pend, pend_nxt;
  logic [XLEN-1:0] pc, pc_d, pc_inc, pend_pc;
  logic            pc_ld, ppc_ld;
  logic            fetch_valid;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(pc_ld), .d(pc_d), .q(pc)
  );

  // Redirect that arrives while a read is in flight is parked here until the read retires.
  pc_reg #(.RESET_VAL(RESET_PC)) u_pend_pc (
    .clk(clk), .rst(rst), .load(ppc_ld), .d(redirect_pc), .q(pend_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  assign pc_inc      = pc + XLEN'(2);
  assign fetch_valid = rst & imem_done & ~pend & ~redirect_valid & (state != ST_HALTED);

  // Priority: redirect > pending redirect > stall_fetch > advance.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    pc_ld     = 1'b0;
    pc_d      = pc_inc;
    ppc_ld    = 1'b0;
    if (redirect_valid) begin
      if (imem_done || !imem_stall) begin
        pc_ld     = 1'b1;
        pc_d      = redirect_pc;
        pend_nxt  = 1'b0;
        state_nxt = ST_RUN;
      end else begin
        ppc_ld    = 1'b1;
        pend_nxt  = 1'b1;
        state_nxt = ST_WAIT;
      end
    end else if (state != ST_HALTED) begin
      if (pend) begin
        if (imem_done) begin
          pc_ld     = 1'b1;
          pc_d      = pend_pc;
          pend_nxt  = 1'b0;
          state_nxt = ST_RUN;
        end
      end else if (imem_done) begin
        state_nxt = ST_RUN;
        if (!stall_fetch) begin
          pc_ld = 1'b1;
          if (opcode(imem_data) == HALT_OPC) state_nxt = ST_HALTED;
        end
      end else if (imem_stall) begin
        state_nxt = ST_WAIT;
      end
    end
  end

  assign imem_addr      = pc;
  assign imem_rd        = rst & (state != ST_HALTED);
  assign instruction    = fetch_valid ? imem_data : NOP_INSTR;
  assign flush_fetch    = ~fetch_valid;
  assign incremented_pc = pc_inc;
  assign halted         = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal pins plus randomized traffic.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_fetch = 1'b0, redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] imem_addr, imem_data = 16'h0, instruction, incremented_pc;
  logic        imem_rd, imem_done = 1'b0, imem_stall = 1'b0, flush_fetch, halted;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_fetch(stall_fetch), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_done(imem_done), .imem_stall(imem_stall),
    .instruction(instruction), .incremented_pc(incremented_pc),
    .flush_fetch(flush_fetch), .halted(halted)
  );

  always #5 clk = ~clk;

  int unsigned total = 0, passed = 0;
  logic [15:0] mem [256];

  // Reference model: architectural PC, deferred redirect and halt flag only.
  logic [15:0] mpc, mpend_pc;
  bit          mpend, mhalt;
  logic [15:0] o_addr, o_instr, o_inc;
  logic        o_flush, o_rd, o_halted;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
  endfunction

  function automatic void model_reset();
    mpc = 16'h0000; mpend = 0; mhalt = 0; mpend_pc = 16'h0000;
  endfunction

  function automatic void check_all();
    bit fv;
    fv = rst && imem_done && !mpend && !redirect_valid && !mhalt;
    o_addr = imem_addr; o_instr = instruction; o_inc = incremented_pc;
    o_flush = flush_fetch; o_rd = imem_rd; o_halted = halted;
    chk("imem_addr", o_addr, mpc);
    chk("instruction", o_instr, fv ? imem_data : 16'h0800);
    chk("incremented_pc", o_inc, mpc + 16'd2);
    chk("flush_fetch", 16'(o_flush), 16'(!fv));
    chk("imem_rd", 16'(o_rd), 16'(rst && !mhalt));
    chk("halted", 16'(o_halted), 16'(mhalt));
  endfunction

  function automatic void model_step();
    if (redirect_valid) begin
      mhalt = 0;
      if (imem_done || !imem_stall) begin mpc = redirect_pc; mpend = 0; end
      else begin mpend_pc = redirect_pc; mpend = 1; end
    end else if (!mhalt) begin
      if (mpend) begin
        if (imem_done) begin mpc = mpend_pc; mpend = 0; end
      end else if (imem_done && !stall_fetch) begin
        if (imem_data[15:11] == 5'd0) mhalt = 1;
        mpc = mpc + 16'd2;
      end
    end
  endfunction

  task automatic cyc(input bit sf, input bit rv, input logic [15:0] rpc, input bit done);
    @(negedge clk);
    stall_fetch = sf; redirect_valid = rv; redirect_pc = rpc;
    imem_done = done; imem_stall = !done;
    imem_data = done ? mem[mpc[8:1]] : 16'($urandom);
    #1 check_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; model_reset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i * 2);
    mem[0] = 16'h1111; mem[1] = 16'h2222;
    model_reset();
    do_reset();
    chk("t0 reset flush", 16'(o_flush), 16'h1);
    chk("t0 reset rd", 16'(o_rd), 16'h0);

    // Perfect memory streams one instruction per cycle.
    cyc(0, 0, 16'h0, 1);
    chk("t1 addr0", o_addr, 16'h0000); chk("t1 instr0", o_instr, 16'h1111);
    chk("t1 inc0", o_inc, 16'h0002);   chk("t1 flush0", 16'(o_flush), 16'h0);
    cyc(0, 0, 16'h0, 1);
    chk("t1 addr1", o_addr, 16'h0002); chk("t1 instr1", o_instr, 16'h2222);
    chk("t1 inc1", o_inc, 16'h0004);

    // Hazard stall holds the PC.
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 16'h0, 1);
      chk("t2 addr held", o_addr, 16'h0004); chk("t2 inc held", o_inc, 16'h0006);
    end
    cyc(0, 0, 16'h0, 1);
    chk("t2 addr release", o_addr, 16'h0004);
    cyc(0, 1, 16'h0010, 1);
    chk("t2 addr after", o_addr, 16'h0006);
    chk("t2 redirect bubble", 16'(o_flush), 16'h1);

    // Variable-latency memory.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 16'h0, 0);
      chk("t3 stall flush", 16'(o_flush), 16'h1); chk("t3 stall nop", o_instr, 16'h0800);
      chk("t3 stall addr", o_addr, 16'h0010);
    end
    cyc(0, 0, 16'h0, 1);
    chk("t3 data", o_instr, 16'h8010); chk("t3 flush", 16'(o_flush), 16'h0);
    cyc(0, 1, 16'h0010, 1);
    chk("t3 next addr", o_addr, 16'h0012);

    // Redirect during an in-flight access is deferred and the returned data dropped.
    cyc(0, 0, 16'h0, 0);
    cyc(0, 1, 16'h0040, 0);
    chk("t4 pend flush", 16'(o_flush), 16'h1);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 1);
    chk("t4 discard", 16'(o_flush), 16'h1); chk("t4 discard nop", o_instr, 16'h0800);
    cyc(0, 0, 16'h0, 1);
    chk("t4 target addr", o_addr, 16'h0040); chk("t4 target instr", o_instr, 16'h8040);

    // HALT is delivered once, then fetch stops until a redirect.
    mem[3] = 16'h0000;
    cyc(0, 1, 16'h0006, 1);
    cyc(0, 0, 16'h0, 1);
    chk("t5 halt addr", o_addr, 16'h0006); chk("t5 halt instr", o_instr, 16'h0000);
    chk("t5 halt flush", 16'(o_flush), 16'h0); chk("t5 halt not yet", 16'(o_halted), 16'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 16'h0, 1);
      chk("t5 halted", 16'(o_halted), 16'h1); chk("t5 rd off", 16'(o_rd), 16'h0);
      chk("t5 nop", o_instr, 16'h0800);
    end
    cyc(0, 1, 16'h0020, 1);
    cyc(0, 0, 16'h0, 1);
    chk("t5 resume addr", o_addr, 16'h0020); chk("t5 resume halted", 16'(o_halted), 16'h0);
    chk("t5 resume instr", o_instr, 16'h8020);

    // Async reset mid-access with a deferred redirect outstanding.
    cyc(0, 0, 16'h0, 0);
    cyc(0, 1, 16'h0080, 0);
    @(negedge clk);
    redirect_valid = 0; imem_done = 0; imem_stall = 1;
    #2 rst = 1'b0; model_reset();
    #1 check_all();
    chk("t6 addr", o_addr, 16'h0000); chk("t6 halted", 16'(o_halted), 16'h0);
    chk("t6 flush", 16'(o_flush), 16'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 16'h0, 1);
      chk("t6 restart addr", o_addr, 16'(k * 2));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 2047))
                                            : {5'($urandom_range(1, 31)), 11'($urandom)};
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          16'($urandom_range(0, 255)) << 1, $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
